// File: rtl/writeback_unit.sv
// Register-file write-port arbiter: ALU results vs. a small load-return FIFO; optional busy scoreboard (WRITEBACK_SCOREBOARD_EN).
// Latency: ALU write in the same cycle; a buffered load is written no earlier than the cycle after it is accepted.
// Backpressure: ld_ready_o drops while the FIFO is full; stall_o holds the ALU stream when the FIFO head starves.
module writeback_unit #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          alu_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]      alu_rd_i,
    input  logic [DATA_WIDTH-1:0]         alu_data_i,
    input  logic                          ld_issue_i,
    input  logic [ADDRESS_WIDTH-1:0]      ld_issue_rd_i,
    input  logic                          ld_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]      ld_rd_i,
    input  logic [DATA_WIDTH-1:0]         ld_data_i,
    output logic                          ld_ready_o,
    output logic [ADDRESS_WIDTH-1:0]      A3_o,
    output logic [DATA_WIDTH-1:0]         WD3_o,
    output logic                          WE3_o,
    output logic [2**ADDRESS_WIDTH-1:0]   busy_o,
    output logic                          stall_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [PW:0]               wr_ptr;
    logic [PW:0]               rd_ptr;
    logic [ADDRESS_WIDTH-1:0]  mem_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     mem_data [FIFO_DEPTH];
    logic                      ready_q;
    logic                      stall_q;
    logic [CW-1:0]             cnt_q;
    logic [CW-1:0]             cnt_next;
    logic                      empty;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic                      alu_req;
    logic                      alu_win;
    logic                      fifo_win;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ld_ready_o = ready_q && !full;
    assign stall_o    = stall_q;

    // Writes are gated by rst_ni so nothing reaches the regfile while reset is held.
    assign alu_req  = alu_valid_i && (alu_rd_i != '0);
    assign fifo_win = rst_ni && !empty && (stall_q || !alu_req);
    assign alu_win  = rst_ni && alu_req && !stall_q;
    assign push     = ld_valid_i && ld_ready_o && (ld_rd_i != '0);
    assign pop      = fifo_win;

    always_comb begin
        WE3_o = 1'b0;
        A3_o  = '0;
        WD3_o = '0;
        if (fifo_win) begin
            WE3_o = 1'b1;
            A3_o  = mem_rd[rd_ptr[PW-1:0]];
            WD3_o = mem_data[rd_ptr[PW-1:0]];
        end else if (alu_win) begin
            WE3_o = 1'b1;
            A3_o  = alu_rd_i;
            WD3_o = alu_data_i;
        end
    end

    // Head lost to the ALU this cycle: count it, saturating at the limit.
    always_comb begin
        cnt_next = cnt_q;
        if (empty || pop) begin
            cnt_next = '0;
        end else if (alu_win && (cnt_q != LIMIT)) begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt_q   <= cnt_next;
            stall_q <= (cnt_next >= LIMIT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd[wr_ptr[PW-1:0]]   <= ld_rd_i;
            mem_data[wr_ptr[PW-1:0]] <= ld_data_i;
        end
    end

`ifdef WRITEBACK_SCOREBOARD_EN
    logic [2**ADDRESS_WIDTH-1:0] busy_q;
    logic [2**ADDRESS_WIDTH-1:0] busy_next;

    // Clear first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_next = busy_q;
        if (pop) begin
            busy_next[A3_o] = 1'b0;
        end
        if (ld_issue_i && (ld_issue_rd_i != '0)) begin
            busy_next[ld_issue_rd_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_o = busy_q;
`else
    logic unused_ld_issue;
    assign unused_ld_issue = ^{ld_issue_i, ld_issue_rd_i};
    assign busy_o          = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: vector table for same-cycle arbitration, directed sequences
// for load latency, FIFO full, starvation, scoreboard set/clear and mid-run reset.
module tb_writeback_unit;

    localparam int AW = 5;
    localparam int DW = 32;

`ifdef WRITEBACK_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           alu_valid;
    logic [AW-1:0]  alu_rd;
    logic [DW-1:0]  alu_data;
    logic           ld_issue;
    logic [AW-1:0]  ld_issue_rd;
    logic           ld_valid;
    logic [AW-1:0]  ld_rd;
    logic [DW-1:0]  ld_data;
    logic           ld_ready;
    logic [AW-1:0]  a3;
    logic [DW-1:0]  wd3;
    logic           we3;
    logic [31:0]    busy;
    logic           stall;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .alu_valid_i   (alu_valid),
        .alu_rd_i      (alu_rd),
        .alu_data_i    (alu_data),
        .ld_issue_i    (ld_issue),
        .ld_issue_rd_i (ld_issue_rd),
        .ld_valid_i    (ld_valid),
        .ld_rd_i       (ld_rd),
        .ld_data_i     (ld_data),
        .ld_ready_o    (ld_ready),
        .A3_o          (a3),
        .WD3_o         (wd3),
        .WE3_o         (we3),
        .busy_o        (busy),
        .stall_o       (stall)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] ad;
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ld;
        logic          ewe;
        logic [AW-1:0] ea3;
        logic [DW-1:0] ewd;
    } vec_t;
    vec_t vecs[12];

    function automatic logic [31:0] bz(input logic [31:0] v);
        return SB_EN ? v : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_check();
        wr_t e;
        if (we3) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: got x%0d=0x%0h, expected no write", a3, wd3);
            end else begin
                e = exp_q.pop_front();
                if (a3 !== e.a || wd3 !== e.d) begin
                    errors++;
                    $display("FAIL sb_write: got x%0d=0x%0h, expected x%0d=0x%0h", a3, wd3, e.a, e.d);
                end
            end
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldd);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldd;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic adv();
        sb_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0};
        vecs[2]  = '{1'b0, 5'd9,  32'hCAFEF00D, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0};
        vecs[3]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,   1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0,  32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0};
        vecs[6]  = '{1'b1, 5'd1,  32'h1,        1'b1, 5'd2, 32'h22,  1'b1, 5'd1,  32'h1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd2,  32'h22};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0};
        vecs[9]  = '{1'b1, 5'd0,  32'h99,       1'b1, 5'd4, 32'h44,  1'b0, 5'd0,  32'h0};
        vecs[10] = '{1'b1, 5'd0,  32'h99,       1'b0, 5'd0, 32'h0,   1'b1, 5'd4,  32'h44};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0};

        // Reset: ALU presented but nothing may be written.
        rst_ni      = 1'b0;
        ld_issue    = 1'b0;
        ld_issue_rd = '0;
        drive(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'h0);
        settle();
        chk("rst_we", we3, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd", wd3, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("ready_before_edge", ld_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", ld_ready, 1);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            settle();
            chk($sformatf("vec%0d_we", i), we3, vecs[i].ewe);
            chk($sformatf("vec%0d_a3", i), a3, vecs[i].ea3);
            chk($sformatf("vec%0d_wd", i), wd3, vecs[i].ewd);
            chk($sformatf("vec%0d_ready", i), ld_ready, 1);
            chk($sformatf("vec%0d_stall", i), stall, 0);
            if (vecs[i].ewe) expect_wr(vecs[i].ea3, vecs[i].ewd);
            adv();
        end

        // Load with idle ALU: issue x7, return one cycle later, write the cycle after.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        settle();
        chk("ld_busy_pre", busy, 0);
        adv();
        ld_issue = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        settle();
        chk("ld_busy_set", busy, bz(32'h80));
        chk("ld_no_bypass", we3, 0);
        adv();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("ld_we", we3, 1);
        chk("ld_a3", a3, 7);
        chk("ld_wd", wd3, 32'h1234);
        chk("ld_busy_hold", busy, bz(32'h80));
        expect_wr(5'd7, 32'h1234);
        adv();
        settle();
        chk("ld_busy_clr", busy, 0);
        chk("ld_idle_we", we3, 0);
        adv();

        // FIFO full: ALU every cycle, three returns offered; third is refused.
        drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA);
        settle(); chk("full_rdy0", ld_ready, 1); expect_wr(5'd10, 32'hA0); adv();
        drive(1'b1, 5'd12, 32'hA1, 1'b1, 5'd13, 32'hB);
        settle(); chk("full_rdy1", ld_ready, 1); expect_wr(5'd12, 32'hA1); adv();
        drive(1'b1, 5'd14, 32'hA2, 1'b1, 5'd15, 32'hC);
        settle(); chk("full_rdy2", ld_ready, 0); expect_wr(5'd14, 32'hA2); adv();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'hD);
        settle(); chk("no_pushthrough", ld_ready, 0); chk("full_pop_a3", a3, 11);
        expect_wr(5'd11, 32'hA); adv();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle(); chk("full_rdy_back", ld_ready, 1); expect_wr(5'd13, 32'hB); adv();
        settle(); chk("full_drained_we", we3, 0); adv();
        chk("full_sb_drain", exp_q.size(), 0);

        // Starvation: one buffered load against continuous ALU traffic.
        drive(1'b1, 5'd20, 32'hC0, 1'b1, 5'd21, 32'h5A5A);
        settle(); expect_wr(5'd20, 32'hC0); adv();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'd22, 32'hC0 + i, 1'b0, 5'd0, 32'h0);
            settle();
            chk($sformatf("starve_stall_c%0d", i), stall, 0);
            expect_wr(5'd22, 32'hC0 + i);
            adv();
        end
        drive(1'b1, 5'd23, 32'hD5, 1'b0, 5'd0, 32'h0);
        settle();
        chk("starve_stall_on", stall, 1);
        chk("starve_ld_a3", a3, 21);
        chk("starve_ld_wd", wd3, 32'h5A5A);
        expect_wr(5'd21, 32'h5A5A);
        adv();
        settle();
        chk("starve_stall_off", stall, 0);
        chk("starve_held_a3", a3, 23);
        expect_wr(5'd23, 32'hD5);
        adv();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle(); chk("starve_idle_we", we3, 0); adv();

        // Issue to x3 in the same cycle as a FIFO write to x3: set wins.
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        settle(); adv();
        ld_issue = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
        settle(); chk("sim_busy_set", busy, bz(32'h08)); adv();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        settle(); chk("sim_we_a3", a3, 3); expect_wr(5'd3, 32'h33); adv();
        ld_issue = 1'b0;
        settle(); chk("sim_busy_kept", busy, bz(32'h08)); adv();

        // Mid-run reset with two buffered loads and busy = x3|x7.
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd7, 32'h77);
        settle(); expect_wr(5'd1, 32'h101); adv();
        ld_issue = 1'b0;
        drive(1'b1, 5'd2, 32'h102, 1'b1, 5'd3, 32'h333);
        settle(); chk("mr_busy", busy, bz(32'h88)); expect_wr(5'd2, 32'h102); adv();
        drive(1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'h0);
        settle();
        chk("mr_full", ld_ready, 0);
        rst_ni = 1'b0;
        #1;
        chk("mr_we", we3, 0);
        chk("mr_a3", a3, 0);
        chk("mr_wd", wd3, 0);
        chk("mr_busy_clr", busy, 0);
        chk("mr_ready", ld_ready, 0);
        @(posedge clk);
        #1;
        settle();
        chk("mr_held_we", we3, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("mr_ready_low", ld_ready, 0);
        @(posedge clk);
        #1;
        chk("mr_ready_high", ld_ready, 1);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("mr_no_stale%0d", i), we3, 0);
            adv();
        end
        chk("mr_busy_after", busy, 0);
        chk("final_sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
